// File: rtl/tempsense_freq_counter.sv
// Temperature-sensor oscillator frequency counter: gated edge counting, 2^AVG_LOG2-window averaging, valid/ready result.
// Optional min/max tracking of published codes is compiled in with `define TEMPSENS_MINMAX_EN.
module tempsense_freq_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             busy
`ifdef TEMPSENS_MINMAX_EN
    ,
    input  logic             clear_minmax,
    output logic [CNT_W-1:0] min_code,
    output logic [CNT_W-1:0] max_code
`endif
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_ACCUM   = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              win_ovf_q, win_ovf_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              overflow_q, overflow_d;

    logic              edge_det;
    logic              enter_measure;
    logic              publish;
    logic [ACC_W-1:0]  acc_new;
    logic [CNT_W-1:0]  pub_code;

    assign edge_det = sync2_q & ~sync3_q;
    assign acc_new  = acc_q + ACC_W'(edge_cnt_q);
    assign pub_code = CNT_W'(acc_new >> AVG_LOG2);

    always_comb begin
        state_d        = state_q;
        sync1_d        = osc_in;
        sync2_d        = sync1_q;
        sync3_d        = sync2_q;
        edge_cnt_d     = edge_cnt_q;
        gate_d         = gate_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        win_ovf_d      = win_ovf_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overflow_d     = overflow_q;
        enter_measure  = 1'b0;
        publish        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d       = ST_MEASURE;
                    enter_measure = 1'b1;
                end
            end
            ST_MEASURE: begin
                // Saturate rather than wrap; a lost edge is reported via the overflow flag.
                if (edge_det) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        win_ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (gate_q == '0) begin
                    state_d = ST_ACCUM;
                end else begin
                    gate_d = gate_q - GATE_W'(1);
                end
            end
            ST_ACCUM: begin
                acc_d = acc_new;
                if (idx_q == IDX_LAST) begin
                    publish        = 1'b1;
                    result_d       = pub_code;
                    overflow_d     = win_ovf_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_HOLD;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    edge_cnt_d = '0;
                    gate_d     = GATE_LOAD;
                    state_d    = ST_MEASURE;
                end
            end
            ST_HOLD: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    if (continuous) begin
                        state_d       = ST_MEASURE;
                        enter_measure = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_measure) begin
            edge_cnt_d = '0;
            gate_d     = GATE_LOAD;
            idx_d      = '0;
            acc_d      = '0;
            win_ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            edge_cnt_q     <= '0;
            gate_q         <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            win_ovf_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            edge_cnt_q     <= edge_cnt_d;
            gate_q         <= gate_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            win_ovf_q      <= win_ovf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == ST_MEASURE) || (state_q == ST_ACCUM);

`ifdef TEMPSENS_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             mm_valid_q, mm_valid_d;

    // A publish overrides a simultaneous clear: both extremes restart from the new code.
    always_comb begin
        min_d      = min_q;
        max_d      = max_q;
        mm_valid_d = mm_valid_q;
        if (publish) begin
            mm_valid_d = 1'b1;
            if (clear_minmax || !mm_valid_q) begin
                min_d = pub_code;
                max_d = pub_code;
            end else begin
                if (pub_code < min_q) min_d = pub_code;
                if (pub_code > max_q) max_d = pub_code;
            end
        end else if (clear_minmax) begin
            mm_valid_d = 1'b0;
            min_d      = '0;
            max_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q      <= '0;
            max_q      <= '0;
            mm_valid_q <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            mm_valid_q <= mm_valid_d;
        end
    end

    assign min_code = min_q;
    assign max_code = max_q;
`endif

endmodule

// File: tb/tb_tempsense_freq_counter.sv
// Directed bench for tempsense_freq_counter: a 16-bit and an 8-bit instance share control, each has its own oscillator.
module tb_tempsense_freq_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic ready = 1'b1;
    logic osc16 = 1'b0;
    logic osc8 = 1'b0;
    logic [15:0] result16;
    logic        valid16, ovf16, busy16;
    logic [7:0]  result8;
    logic        valid8, ovf8, busy8;
`ifdef TEMPSENS_MINMAX_EN
    logic        clr = 1'b0;
    logic [15:0] min16, max16;
    logic [7:0]  min8, max8;
`endif

    int half16 = 0;
    int half8 = 0;
    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;
    bit sel8 = 1'b0;

    tempsense_freq_counter #(.GATE_CYCLES(1000), .CNT_W(16), .AVG_LOG2(2)) dut16 (
        .clk(clk), .rst(rst), .osc_in(osc16), .start(start), .continuous(continuous),
        .result(result16), .result_valid(valid16), .result_ready(ready),
        .overflow(ovf16), .busy(busy16)
`ifdef TEMPSENS_MINMAX_EN
        , .clear_minmax(clr), .min_code(min16), .max_code(max16)
`endif
    );

    tempsense_freq_counter #(.GATE_CYCLES(1000), .CNT_W(8), .AVG_LOG2(2)) dut8 (
        .clk(clk), .rst(rst), .osc_in(osc8), .start(start), .continuous(continuous),
        .result(result8), .result_valid(valid8), .result_ready(ready),
        .overflow(ovf8), .busy(busy8)
`ifdef TEMPSENS_MINMAX_EN
        , .clear_minmax(clr), .min_code(min8), .max_code(max8)
`endif
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillators: period = 2*half clk cycles, phase offset so edges never coincide with clk edges.
    initial begin
        #3;
        forever begin
            if (half16 == 0) begin osc16 = 1'b0; #10; end
            else begin #(half16 * 10); osc16 = ~osc16; end
        end
    end
    initial begin
        #3;
        forever begin
            if (half8 == 0) begin osc8 = 1'b0; #10; end
            else begin #(half8 * 10); osc8 = ~osc8; end
        end
    end

    function automatic logic sel_valid();
        return sel8 ? valid8 : valid16;
    endfunction
    function automatic int sel_result();
        return sel8 ? int'(result8) : int'(result16);
    endfunction
    function automatic logic sel_ovf();
        return sel8 ? ovf8 : ovf16;
    endfunction
    function automatic logic sel_busy();
        return sel8 ? busy8 : busy16;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
            $display("check %-28s got %0d expected %0d ok", name, act, exp);
        end else begin
            $display("FAIL %-28s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is high for one cycle; returning after the sampling edge counts as cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int n0, input int budget, output int n);
        n = n0;
        while (!sel_valid() && n < budget) begin
            step();
            n++;
        end
    endtask

    typedef struct {
        string name;
        int    half_p;
        bit    use8;
        int    exp_res;
        bit    exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int t1, t2, t3;
        int cnt, held;

        vecs[0] = '{"nominal_p4",     2, 1'b0, 250, 1'b0};
        vecs[1] = '{"p8",             4, 1'b0, 125, 1'b0};
        vecs[2] = '{"sat8_p2",        1, 1'b1, 255, 1'b1};
        vecs[3] = '{"after_sat8_p16", 8, 1'b1,  62, 1'b0};
        vecs[4] = '{"idle_osc",       0, 1'b0,   0, 1'b0};
        vecs[5] = '{"p2_16bit",       1, 1'b0, 500, 1'b0};

        repeat (3) step();
        check("reset_result", result16, 0);
        check("reset_valid", valid16, 0);
        check("reset_overflow", ovf16, 0);
        check("reset_busy", busy16, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            sel8 = vecs[i].use8;
            if (vecs[i].use8) half8 = vecs[i].half_p;
            else half16 = vecs[i].half_p;
            ready = 1'b1;
            repeat (20) step();
            pulse_start();
            check({vecs[i].name, "_busy"}, sel_busy(), 1);
            wait_valid(1, 5000, n);
            check({vecs[i].name, "_latency"}, n, 4005);
            check({vecs[i].name, "_result"}, sel_result(), vecs[i].exp_res);
            check({vecs[i].name, "_ovf"}, sel_ovf(), vecs[i].exp_ovf);
            step();
            check({vecs[i].name, "_valid_clr"}, sel_valid(), 0);
            check({vecs[i].name, "_busy_after"}, sel_busy(), 0);
            check({vecs[i].name, "_result_kept"}, sel_result(), vecs[i].exp_res);
        end
`ifdef TEMPSENS_MINMAX_EN
        check("minmax_min16", min16, 0);
        check("minmax_max16", max16, 500);
`endif

        // Backpressure: result held while ready is low, single result only.
        sel8 = 1'b0;
        half16 = 2;
        ready = 1'b0;
        repeat (10) step();
        pulse_start();
        wait_valid(1, 5000, n);
        check("bp_latency", n, 4005);
        held = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (valid16 && result16 == 16'd250 && !busy16) held++;
        end
        check("bp_held_cycles", held, 50);
        ready = 1'b1;
        step();
        check("bp_valid_clr", valid16, 0);
        check("bp_busy", busy16, 0);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (valid16 || busy16) cnt++;
        end
        check("bp_no_more_activity", cnt, 0);

        // Continuous mode: results every 4005 cycles; dropping continuous yields one more.
        half16 = 4;
        continuous = 1'b1;
        step();
        wait_valid(1, 5000, n);
        t1 = cyc;
        check("cont_first_result", result16, 125);
        step();
        wait_valid(1, 5000, n);
        t2 = cyc;
        check("cont_spacing", t2 - t1, 4005);
        check("cont_second_result", result16, 125);
        repeat (10) step();
        continuous = 1'b0;
        cnt = 0;
        t3 = 0;
        for (int k = 0; k < 9000; k++) begin
            step();
            if (valid16) begin
                cnt++;
                t3 = cyc;
                check("cont_last_result", result16, 125);
            end
        end
        check("cont_extra_results", cnt, 1);
        check("cont_last_spacing", t3 - t2, 4005);
        check("cont_idle_busy", busy16, 0);

        // Reset at cycle 2000 of a run, then a fresh measurement.
        half16 = 2;
        repeat (5) step();
        pulse_start();
        repeat (1999) step();
        rst = 1'b1;
        step();
        check("rst_mid_valid", valid16, 0);
        check("rst_mid_busy", busy16, 0);
        check("rst_mid_result", result16, 0);
        rst = 1'b0;
        step();
        pulse_start();
        wait_valid(1, 5000, n);
        check("rst_fresh_latency", n, 4005);
        check("rst_fresh_result", result16, 250);

        // Idle oscillator, second start during MEASURE must be ignored.
        half16 = 0;
        repeat (10) step();
`ifdef TEMPSENS_MINMAX_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clear_min16", min16, 0);
        check("clear_max16", max16, 0);
`endif
        pulse_start();
        repeat (499) step();
        pulse_start();
        wait_valid(501, 5000, n);
        check("ign_latency", n, 4005);
        check("ign_result", result16, 0);
        step();
        cnt = 0;
        for (int k = 0; k < 4500; k++) begin
            step();
            if (valid16 || busy16) cnt++;
        end
        check("ign_no_second", cnt, 0);
`ifdef TEMPSENS_MINMAX_EN
        check("ign_min16", min16, 0);
        check("ign_max16", max16, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
